// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
//   Multi-cycle sequencer for the MIPS datapath. Steps each instruction
//   through FETCH, DECODE, EXEC, MEM and WB, one state per cycle, waiting on
//   instruction/data memory ready handshakes. It turns the decoder's
//   combinational controls into single-cycle write strobes. It halts on an
//   exception or on a data-memory timeout.
//
// Parameters
//   STALL_LIMIT  max MEM wait cycles before bus_error (1..255, default 15)
//
// Configuration macro
//   MC_ADDM_EN   defined: addm takes the load path (MEM then WB).
//                undefined: addm=1 is treated as an exception in DECODE.
//
// Ports
//   clk, reset                    clock (rising edge), async active-low reset
//   imem_ready, dmem_ready        memory handshakes
//   writeenable, except, mem_read,
//   word_we, byte_we, addm,
//   control_type[1:0]             decoder outputs for the instruction in IR
//   imem_req, ir_we               fetch request, IR capture strobe
//   dmem_req, dmem_wr             data request, request is a write
//   rf_we, pc_we, pc_sel[1:0]     register file / PC strobes, next-PC select
//   halted, bus_error             machine stopped, sticky timeout flag
//   state[2:0]                    current state encoding (debug)

module mips_multicycle_ctrl #(
  parameter int STALL_LIMIT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  input  logic       writeenable,
  input  logic       except,
  input  logic       mem_read,
  input  logic       word_we,
  input  logic       byte_we,
  input  logic       addm,
  input  logic [1:0] control_type,
  output logic       imem_req,
  output logic       ir_we,
  output logic       dmem_req,
  output logic       dmem_wr,
  output logic       rf_we,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic       halted,
  output logic       bus_error,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [7:0] LIMIT = STALL_LIMIT[7:0];

  state_t     cur;
  logic [7:0] stall_cnt;
  logic       mem_op;
  logic       addm_exc;
  logic       is_store;
  logic       stall_hit;

  // Without addm support, addm never starts a memory access and instead
  // traps in DECODE like any other unrecognised instruction.
`ifdef MC_ADDM_EN
  assign mem_op   = mem_read | word_we | byte_we | addm;
  assign addm_exc = 1'b0;
`else
  assign mem_op   = mem_read | word_we | byte_we;
  assign addm_exc = addm;
`endif

  assign is_store  = word_we | byte_we;
  // True on the MEM wait cycle that would push the count up to the limit.
  assign stall_hit = (stall_cnt + 8'd1) == LIMIT;
  assign state     = cur;

  // State register plus the registered status flags. Unused codes 6 and 7
  // fall into HALT so a corrupted state never issues strobes for long.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur       <= S_FETCH;
      stall_cnt <= 8'd0;
      halted    <= 1'b0;
      bus_error <= 1'b0;
    end else begin
      case (cur)
        S_FETCH: begin
          if (imem_ready) cur <= S_DECODE;
        end
        S_DECODE: begin
          if (except | addm_exc) begin
            cur    <= S_HALT;
            halted <= 1'b1;
          end else begin
            cur <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (mem_op) begin
            cur       <= S_MEM;
            stall_cnt <= 8'd0;
          end else if (writeenable) begin
            cur <= S_WB;
          end else begin
            cur <= S_FETCH;
          end
        end
        S_MEM: begin
          // Ready takes priority over the timeout on the limit cycle.
          if (dmem_ready) begin
            cur <= is_store ? S_FETCH : S_WB;
          end else if (stall_hit) begin
            cur       <= S_HALT;
            halted    <= 1'b1;
            bus_error <= 1'b1;
          end else begin
            stall_cnt <= stall_cnt + 8'd1;
          end
        end
        S_WB: begin
          cur <= S_FETCH;
        end
        S_HALT: begin
          halted <= 1'b1;
        end
        default: begin
          cur    <= S_HALT;
          halted <= 1'b1;
        end
      endcase
    end
  end

  // Strobes are decoded from the current state and this cycle's inputs so
  // that ir_we and the memory-completion PC write land in the ready cycle.
  // Everything is gated by reset so an in-flight write is killed at once.
  always_comb begin
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_wr  = 1'b0;
    rf_we    = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = 2'b00;
    if (reset) begin
      case (cur)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_we    = imem_ready;
        end
        S_EXEC: begin
          if (!mem_op && !writeenable) begin
            pc_we  = 1'b1;
            pc_sel = control_type;
          end
        end
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_wr  = is_store;
          pc_we    = dmem_ready & is_store;
        end
        S_WB: begin
          rf_we = 1'b1;
          pc_we = 1'b1;
        end
        default: begin
          imem_req = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
module tb_mips_multicycle_ctrl;

  localparam int LIMIT = 15;
`ifdef MC_ADDM_EN
  localparam bit ADDM_EN = 1'b1;
`else
  localparam bit ADDM_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       imem_ready = 1'b0;
  logic       dmem_ready = 1'b0;
  logic       writeenable = 1'b0;
  logic       except = 1'b0;
  logic       mem_read = 1'b0;
  logic       word_we = 1'b0;
  logic       byte_we = 1'b0;
  logic       addm = 1'b0;
  logic [1:0] control_type = 2'b00;
  logic       imem_req, ir_we, dmem_req, dmem_wr, rf_we, pc_we;
  logic [1:0] pc_sel;
  logic       halted, bus_error;
  logic [2:0] state;

  mips_multicycle_ctrl #(.STALL_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .writeenable(writeenable), .except(except), .mem_read(mem_read),
    .word_we(word_we), .byte_we(byte_we), .addm(addm),
    .control_type(control_type),
    .imem_req(imem_req), .ir_we(ir_we), .dmem_req(dmem_req), .dmem_wr(dmem_wr),
    .rf_we(rf_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .halted(halted), .bus_error(bus_error), .state(state)
  );

  always #5 clk = ~clk;

  // Everything observable in one cycle, in a fixed field order.
  typedef struct packed {
    logic [2:0] st;
    logic       imem_req;
    logic       ir_we;
    logic       dmem_req;
    logic       dmem_wr;
    logic       rf_we;
    logic       pc_we;
    logic [1:0] pc_sel;
    logic       halted;
    logic       bus_error;
  } obs_t;

  typedef struct {
    obs_t o;
    bit   irdy;
    bit   drdy;
  } step_t;

  step_t exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic obs_t mk(input logic [2:0] st, input bit imr, input bit irw,
                              input bit dmr, input bit dmw, input bit rfw,
                              input bit pcw, input logic [1:0] sel,
                              input bit h, input bit be);
    obs_t o;
    o.st = st; o.imem_req = imr; o.ir_we = irw; o.dmem_req = dmr;
    o.dmem_wr = dmw; o.rf_we = rfw; o.pc_we = pcw; o.pc_sel = sel;
    o.halted = h; o.bus_error = be;
    return o;
  endfunction

  function automatic void add(input obs_t o, input bit irdy, input bit drdy);
    step_t s;
    s.o = o; s.irdy = irdy; s.drdy = drdy;
    exp_q.push_back(s);
  endfunction

  // Reference: expected per-cycle behaviour of one instruction given its
  // class and how many cycles each memory keeps ready low. States are the
  // published encodings: 0 F, 1 D, 2 E, 3 M, 4 W, 5 HALT.
  function automatic void build_model(input bit we, input bit exc, input bit mr,
                                      input bit ww, input bit bw, input bit am,
                                      input logic [1:0] ct, input int iw, input int dw,
                                      output bit hlt, output bit be);
    bit store, memop;
    exp_q.delete();
    hlt = 1'b0; be = 1'b0;
    store = ww | bw;
    memop = mr | store | (ADDM_EN & am);
    for (int i = 0; i < iw; i++) add(mk(0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0), 1'b0, 1'b0);
    add(mk(0, 1, 1, 0, 0, 0, 0, 2'b00, 0, 0), 1'b1, 1'b0);
    add(mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0), 1'b0, 1'b0);
    if (exc || (!ADDM_EN && am)) begin
      hlt = 1'b1;
      return;
    end
    if (memop) begin
      add(mk(2, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0), 1'b0, 1'b0);
      for (int k = 1; k <= LIMIT; k++) begin
        if (k - 1 == dw) begin
          add(mk(3, 0, 0, 1, store, 0, store, 2'b00, 0, 0), 1'b0, 1'b1);
          if (!store) add(mk(4, 0, 0, 0, 0, 1, 1, 2'b00, 0, 0), 1'b0, 1'b0);
          return;
        end
        add(mk(3, 0, 0, 1, store, 0, 0, 2'b00, 0, 0), 1'b0, 1'b0);
        if (k == LIMIT) begin
          hlt = 1'b1; be = 1'b1;
          return;
        end
      end
    end else if (we) begin
      add(mk(2, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0), 1'b0, 1'b0);
      add(mk(4, 0, 0, 0, 0, 1, 1, 2'b00, 0, 0), 1'b0, 1'b0);
    end else begin
      add(mk(2, 0, 0, 0, 0, 0, 1, ct, 0, 0), 1'b0, 1'b0);
    end
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o = {state, imem_req, ir_we, dmem_req, dmem_wr, rf_we, pc_we, pc_sel, halted, bus_error};
    return o;
  endfunction

  // Runs one instruction cycle by cycle against the model trace, then,
  // if the model says the machine stops, checks it stays in HALT.
  task automatic run_instr(input string name, input bit we, input bit exc, input bit mr,
                           input bit ww, input bit bw, input bit am,
                           input logic [1:0] ct, input int iw, input int dw,
                           output bit hlt);
    bit be;
    obs_t act;
    build_model(we, exc, mr, ww, bw, am, ct, iw, dw, hlt, be);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      if (i == 0) begin
        writeenable = we; except = exc; mem_read = mr;
        word_we = ww; byte_we = bw; addm = am; control_type = ct;
      end
      imem_ready = exp_q[i].irdy;
      dmem_ready = exp_q[i].drdy;
      #1;
      act = observe();
      checks++;
      if (act !== exp_q[i].o) begin
        errors++;
        $display("[TB] FAIL %s cycle %0d: got st=%0d imr=%b irw=%b dmr=%b dmw=%b rfw=%b pcw=%b sel=%b h=%b be=%b, want %b",
                 name, i, act.st, act.imem_req, act.ir_we, act.dmem_req, act.dmem_wr,
                 act.rf_we, act.pc_we, act.pc_sel, act.halted, act.bus_error, exp_q[i].o);
      end
    end
    if (hlt) begin
      for (int j = 0; j < 2; j++) begin
        @(negedge clk);
        imem_ready = 1'b1; dmem_ready = 1'b1;
        #1;
        act = observe();
        checks++;
        if (act !== mk(5, 0, 0, 0, 0, 0, 0, 2'b00, 1, be)) begin
          errors++;
          $display("[TB] FAIL %s halt hold %0d: got %b want %b", name, j, act,
                   mk(5, 0, 0, 0, 0, 0, 0, 2'b00, 1, be));
        end
      end
    end
  endtask

  task automatic do_reset();
    imem_ready = 0; dmem_ready = 0; writeenable = 0; except = 0;
    mem_read = 0; word_we = 0; byte_we = 0; addm = 0; control_type = 2'b00;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    obs_t act;
    #12;
    act = observe();
    checks++;
    if (act !== mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0)) begin
      errors++;
      $display("[TB] FAIL reset_held: got %b want %b", act, mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    act = observe();
    checks++;
    if (act !== mk(0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0)) begin
      errors++;
      $display("[TB] FAIL reset_release: got %b want %b", act, mk(0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0));
    end
  endtask

  task automatic test_alu();
    bit h;
    run_instr("alu", 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, h);
  endtask

  task automatic test_branch();
    bit h;
    run_instr("beq", 0, 0, 0, 0, 0, 0, 2'b01, 0, 0, h);
    run_instr("j", 0, 0, 0, 0, 0, 0, 2'b10, 1, 0, h);
    run_instr("jr", 0, 0, 0, 0, 0, 0, 2'b11, 0, 0, h);
  endtask

  task automatic test_load_wait();
    bit h;
    run_instr("lw_wait3", 0, 0, 1, 0, 0, 0, 2'b00, 0, 3, h);
    run_instr("sb_wait2", 0, 0, 0, 0, 1, 0, 2'b00, 2, 2, h);
  endtask

  task automatic test_store_timeout();
    bit h;
    run_instr("sw_ready_at_limit", 0, 0, 0, 1, 0, 0, 2'b00, 0, LIMIT - 1, h);
    run_instr("sw_timeout", 0, 0, 0, 1, 0, 0, 2'b00, 0, 1000, h);
    do_reset();
  endtask

  task automatic test_except_reset();
    bit h;
    obs_t act;
    run_instr("except", 0, 1, 0, 0, 0, 0, 2'b00, 0, 0, h);
    #2;
    reset = 1'b0;
    #1;
    act = observe();
    checks++;
    if (act !== mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0)) begin
      errors++;
      $display("[TB] FAIL async_reset_from_halt: got %b want %b", act, mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0));
    end
    imem_ready = 0; except = 0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) begin
        imem_ready = 1'b1; writeenable = 1'b1;
      end
      #1;
    end
    checks++;
    if (state !== 3'd4 || rf_we !== 1'b1 || pc_we !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_reset_pre: got st=%0d rfw=%b pcw=%b want st=4 rfw=1 pcw=1", state, rf_we, pc_we);
    end
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (state !== 3'd0 || rf_we !== 1'b0 || pc_we !== 1'b0 || imem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset_drop: got st=%0d rfw=%b pcw=%b imr=%b want 0 0 0 0", state, rf_we, pc_we, imem_req);
    end
    do_reset();
  endtask

  task automatic test_addm();
    bit h;
    run_instr("addm", 0, 0, 0, 0, 0, 1, 2'b00, 0, 0, h);
    if (h) do_reset();
  endtask

  task automatic test_back_to_back();
    bit h;
    int kind, iw, dw;
    logic [1:0] ct;
    bit bsel;
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 4);
      iw   = $urandom_range(0, 2);
      dw   = $urandom_range(0, 5);
      ct   = 2'($urandom_range(0, 3));
      bsel = 1'($urandom_range(0, 1));
      case (kind)
        0: run_instr("rand_alu", 1, 0, 0, 0, 0, 0, 2'b00, iw, dw, h);
        1: run_instr("rand_branch", 0, 0, 0, 0, 0, 0, ct, iw, dw, h);
        2: run_instr("rand_load", 0, 0, 1, 0, 0, 0, 2'b00, iw, dw, h);
        3: run_instr("rand_store", 0, 0, 0, !bsel, bsel, 0, 2'b00, iw, dw, h);
        default: begin
          if (ADDM_EN) run_instr("rand_addm", 0, 0, 0, 0, 0, 1, 2'b00, iw, dw, h);
          else         run_instr("rand_alu2", 1, 0, 0, 0, 0, 0, 2'b00, iw, dw, h);
        end
      endcase
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_alu();
    test_branch();
    test_load_wait();
    test_store_timeout();
    test_except_reset();
    test_reset_mid();
    test_addm();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
